// File: rtl/turf_pkg.sv
// Shared command codes, PS/2 scancodes, FSM state types and the game key map
// for the PS/2 front end of the directions block.
package turf_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {DEC_BASE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_e;

  localparam logic [4:0] CMD_P1_UP    = 5'd0;
  localparam logic [4:0] CMD_P1_DOWN  = 5'd1;
  localparam logic [4:0] CMD_P1_LEFT  = 5'd2;
  localparam logic [4:0] CMD_P1_RIGHT = 5'd3;
  localparam logic [4:0] CMD_P2_UP    = 5'd4;
  localparam logic [4:0] CMD_P2_DOWN  = 5'd5;
  localparam logic [4:0] CMD_P2_LEFT  = 5'd6;
  localparam logic [4:0] CMD_P2_RIGHT = 5'd7;
  localparam logic [4:0] CMD_P3_UP    = 5'd8;
  localparam logic [4:0] CMD_P3_DOWN  = 5'd9;
  localparam logic [4:0] CMD_P3_LEFT  = 5'd10;
  localparam logic [4:0] CMD_P3_RIGHT = 5'd11;
  localparam logic [4:0] CMD_P4_UP    = 5'd12;
  localparam logic [4:0] CMD_P4_DOWN  = 5'd13;
  localparam logic [4:0] CMD_P4_LEFT  = 5'd14;
  localparam logic [4:0] CMD_P4_RIGHT = 5'd15;
  localparam logic [4:0] CMD_RESET    = 5'd16;
  localparam logic [4:0] CMD_IDLE     = 5'd31;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;  // also keypad 8 without E0
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // also keypad 4 without E0
  localparam logic [7:0] SC_RIGHT = 8'h74;  // also keypad 6 without E0
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  function automatic key_map_t map_key(input logic ext, input logic [7:0] sc);
    key_map_t km;
    km.hit  = 1'b1;
    km.code = CMD_IDLE;
    if (ext) begin
      unique case (sc)
        SC_UP:    km.code = CMD_P2_UP;
        SC_DOWN:  km.code = CMD_P2_DOWN;
        SC_LEFT:  km.code = CMD_P2_LEFT;
        SC_RIGHT: km.code = CMD_P2_RIGHT;
        default:  km.hit  = 1'b0;
      endcase
    end else begin
      unique case (sc)
        SC_W:     km.code = CMD_P1_UP;
        SC_S:     km.code = CMD_P1_DOWN;
        SC_A:     km.code = CMD_P1_LEFT;
        SC_D:     km.code = CMD_P1_RIGHT;
        SC_I:     km.code = CMD_P3_UP;
        SC_K:     km.code = CMD_P3_DOWN;
        SC_J:     km.code = CMD_P3_LEFT;
        SC_L:     km.code = CMD_P3_RIGHT;
        SC_UP:    km.code = CMD_P4_UP;
        SC_KP5:   km.code = CMD_P4_DOWN;
        SC_LEFT:  km.code = CMD_P4_LEFT;
        SC_RIGHT: km.code = CMD_P4_RIGHT;
        SC_SPACE: km.code = CMD_RESET;
        default:  km.hit  = 1'b0;
      endcase
    end
    return km;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, start/data/parity/stop FSM and a
// mid-frame watchdog. Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx
  import turf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] scan_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam logic [15:0] WdogMax = 16'(TIMEOUT_CYCLES - 1);

  logic       clk_meta_q, clk_sync_q, clk_prev_q;
  logic       dat_meta_q, dat_sync_q;
  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [15:0] wdog_q, wdog_d;
  logic [7:0] scan_q, scan_d;
  logic       bv_q, bv_d;
  logic       fe_q, fe_d;
  logic       fall;
  logic       good;
`ifdef PS2_PARITY_CHECK_EN
  logic       par_q, par_d;
`endif

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    scan_d    = scan_q;
    bv_d      = 1'b0;
    fe_d      = 1'b0;
    good      = 1'b0;
    wdog_d    = 16'd0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (state_q != RX_IDLE && !fall) begin
      wdog_d = wdog_q + 16'd1;
    end

    unique case (state_q)
      RX_IDLE: begin
        if (fall && !dat_sync_q) begin
          state_d   = RX_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = dat_sync_q;
`endif
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          good = dat_sync_q & (^{shift_q, par_q});
`else
          good = dat_sync_q;
`endif
          state_d = RX_IDLE;
          if (good) begin
            scan_d = shift_q;
            bv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Stalled mid-frame: drop partial bits and flag the frame.
    if (state_q != RX_IDLE && !fall && wdog_q == WdogMax) begin
      state_d = RX_IDLE;
      fe_d    = 1'b1;
      wdog_d  = 16'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      wdog_q     <= 16'd0;
      scan_q     <= 8'h00;
      bv_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wdog_q     <= wdog_d;
      scan_q     <= scan_d;
      bv_q       <= bv_d;
      fe_q       <= fe_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign scan_byte_o  = scan_q;
  assign byte_valid_o = bv_q;
  assign frame_err_o  = fe_q;

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 keyboard to game command mapper: E0/F0 prefix decoder on top of ps2_rx.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking in the receiver.
module ps2_key_mapper
  import turf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [4:0]  IDLE_CODE      = CMD_IDLE
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] key_pressed,
  output logic       key_valid,
  output logic [7:0] scan_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  dec_state_e dec_q, dec_d;
  logic [4:0] key_q, key_d;
  logic       kv_q, kv_d;
  logic       ext, brk;
  key_map_t   km;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (CLOCK_50),
    .rst_ni      (resetn),
    .ps2_clk_i   (PS2_CLK),
    .ps2_dat_i   (PS2_DAT),
    .scan_byte_o (scan_byte),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err)
  );

  assign ext = (dec_q == DEC_E0) || (dec_q == DEC_E0F0);
  assign brk = (dec_q == DEC_F0) || (dec_q == DEC_E0F0);
  assign km  = map_key(ext, scan_byte);

  always_comb begin
    dec_d = dec_q;
    key_d = key_q;
    kv_d  = 1'b0;
    if (frame_err) begin
      dec_d = DEC_BASE;
    end else if (byte_valid) begin
      if (scan_byte == SC_EXT && (dec_q == DEC_BASE || dec_q == DEC_E0)) begin
        dec_d = DEC_E0;
      end else if (scan_byte == SC_BREAK && dec_q == DEC_BASE) begin
        dec_d = DEC_F0;
      end else if (scan_byte == SC_BREAK && dec_q == DEC_E0) begin
        dec_d = DEC_E0F0;
      end else begin
        dec_d = DEC_BASE;
        if (km.hit) begin
          if (brk) begin
            // Only releasing the held key clears the command.
            if (km.code == key_q) key_d = IDLE_CODE;
          end else if (km.code != key_q) begin
            key_d = km.code;
            kv_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dec_q <= DEC_BASE;
      key_q <= IDLE_CODE;
      kv_q  <= 1'b0;
    end else begin
      dec_q <= dec_d;
      key_q <= key_d;
      kv_q  <= kv_d;
    end
  end

  assign key_pressed = key_q;
  assign key_valid   = kv_q;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper: bit-banged PS/2 frames, pulse counters,
// hand-computed expected codes.
module tb_ps2_key_mapper;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [4:0] key_pressed;
  logic       key_valid;
  logic [7:0] scan_byte;
  logic       byte_valid;
  logic       frame_err;

  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;
  int bv_cnt = 0, kv_cnt = 0, fe_cnt = 0;
  longint bv_cyc = 0, kv_cyc = 0;

  ps2_key_mapper dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .key_pressed(key_pressed),
    .key_valid  (key_valid),
    .scan_byte  (scan_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (byte_valid) begin
      bv_cnt <= bv_cnt + 1;
      bv_cyc <= cyc;
    end
    if (key_valid) begin
      kv_cnt <= kv_cnt + 1;
      kv_cyc <= cyc;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_cyc(8);
    PS2_CLK = 1'b0;
    wait_cyc(10);
    PS2_CLK = 1'b1;
    wait_cyc(2);
  endtask

  // Sends the first n_edges bits of a frame (11 = complete frame).
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int n_edges);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n_edges; i++) ps2_bit(bits[i]);
    PS2_DAT = 1'b1;
    wait_cyc(6);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    wait_cyc(3);
    n_vec++; if (key_pressed !== 5'd31) begin n_err++;
      $display("FAIL reset_key: got %0d expected 31", key_pressed); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    n_vec++; if (scan_byte !== 8'h00) begin n_err++;
      $display("FAIL reset_scan_byte: got %h expected 00", scan_byte); end
    n_vec++; if (byte_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++;
      $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    resetn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_make;
    int bv0, kv0;
    bv0 = bv_cnt; kv0 = kv_cnt;
    send_frame(8'h1D, 1'b0, 11);
    n_vec++; if (scan_byte !== 8'h1D) begin n_err++;
      $display("FAIL make_scan_byte: got %h expected 1d", scan_byte); end
    n_vec++; if (bv_cnt - bv0 !== 1) begin n_err++;
      $display("FAIL make_byte_pulses: got %0d expected 1", bv_cnt - bv0); end
    n_vec++; if (kv_cnt - kv0 !== 1) begin n_err++;
      $display("FAIL make_key_pulses: got %0d expected 1", kv_cnt - kv0); end
    n_vec++; if (kv_cyc - bv_cyc !== 1) begin n_err++;
      $display("FAIL make_key_latency: got %0d expected 1", kv_cyc - bv_cyc); end
    n_vec++; if (key_pressed !== 5'd0) begin n_err++;
      $display("FAIL make_key: got %0d expected 0", key_pressed); end
  endtask

  task automatic test_extended;
    int kv0;
    kv0 = kv_cnt;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd7) begin n_err++;
      $display("FAIL ext_make_key: got %0d expected 7", key_pressed); end
    n_vec++; if (kv_cnt - kv0 !== 1) begin n_err++;
      $display("FAIL ext_make_pulses: got %0d expected 1", kv_cnt - kv0); end
    kv0 = kv_cnt;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h74, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd31) begin n_err++;
      $display("FAIL ext_break_key: got %0d expected 31", key_pressed); end
    n_vec++; if (kv_cnt - kv0 !== 0) begin n_err++;
      $display("FAIL ext_break_pulses: got %0d expected 0", kv_cnt - kv0); end
  endtask

  task automatic test_repeat;
    int kv0;
    kv0 = kv_cnt;
    send_frame(8'h75, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd12) begin n_err++;
      $display("FAIL kp_make_key: got %0d expected 12", key_pressed); end
    n_vec++; if (kv_cnt - kv0 !== 1) begin n_err++;
      $display("FAIL kp_make_pulses: got %0d expected 1", kv_cnt - kv0); end
    kv0 = kv_cnt;
    send_frame(8'h75, 1'b0, 11);
    n_vec++; if (kv_cnt - kv0 !== 0) begin n_err++;
      $display("FAIL repeat_pulses: got %0d expected 0", kv_cnt - kv0); end
    n_vec++; if (key_pressed !== 5'd12) begin n_err++;
      $display("FAIL repeat_key: got %0d expected 12", key_pressed); end
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1D, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd12) begin n_err++;
      $display("FAIL other_break_key: got %0d expected 12", key_pressed); end
  endtask

  task automatic test_timeout;
    int fe0, bv0, kv0;
    fe0 = fe_cnt; bv0 = bv_cnt;
    send_frame(8'h55, 1'b0, 5);
    wait_cyc(50100);
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++;
      $display("FAIL timeout_err_pulses: got %0d expected 1", fe_cnt - fe0); end
    n_vec++; if (bv_cnt - bv0 !== 0) begin n_err++;
      $display("FAIL timeout_byte_pulses: got %0d expected 0", bv_cnt - bv0); end
    kv0 = kv_cnt;
    send_frame(8'h29, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd16) begin n_err++;
      $display("FAIL space_key: got %0d expected 16", key_pressed); end
    n_vec++; if (kv_cnt - kv0 !== 1) begin n_err++;
      $display("FAIL space_pulses: got %0d expected 1", kv_cnt - kv0); end
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++;
      $display("FAIL space_err_pulses: got %0d expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_parity;
    int fe0, bv0;
    fe0 = fe_cnt; bv0 = bv_cnt;
    send_frame(8'h43, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++;
      $display("FAIL parity_err_pulses: got %0d expected 1", fe_cnt - fe0); end
    n_vec++; if (bv_cnt - bv0 !== 0) begin n_err++;
      $display("FAIL parity_byte_pulses: got %0d expected 0", bv_cnt - bv0); end
    n_vec++; if (key_pressed !== 5'd16) begin n_err++;
      $display("FAIL parity_key: got %0d expected 16", key_pressed); end
`else
    n_vec++; if (fe_cnt - fe0 !== 0) begin n_err++;
      $display("FAIL parity_err_pulses: got %0d expected 0", fe_cnt - fe0); end
    n_vec++; if (bv_cnt - bv0 !== 1) begin n_err++;
      $display("FAIL parity_byte_pulses: got %0d expected 1", bv_cnt - bv0); end
    n_vec++; if (key_pressed !== 5'd8) begin n_err++;
      $display("FAIL parity_key: got %0d expected 8", key_pressed); end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int kv0;
    send_frame(8'h1C, 1'b0, 5);
    resetn = 1'b0;
    #1;
    n_vec++; if (key_pressed !== 5'd31) begin n_err++;
      $display("FAIL midreset_key: got %0d expected 31", key_pressed); end
    n_vec++; if (scan_byte !== 8'h00) begin n_err++;
      $display("FAIL midreset_scan_byte: got %h expected 00", scan_byte); end
    n_vec++; if ({key_valid, byte_valid, frame_err} !== 3'b000) begin n_err++;
      $display("FAIL midreset_pulses: got %b expected 000", {key_valid, byte_valid, frame_err}); end
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(3);
    kv0 = kv_cnt;
    send_frame(8'h1C, 1'b0, 11);
    n_vec++; if (key_pressed !== 5'd2) begin n_err++;
      $display("FAIL after_reset_key: got %0d expected 2", key_pressed); end
    n_vec++; if (scan_byte !== 8'h1C) begin n_err++;
      $display("FAIL after_reset_scan_byte: got %h expected 1c", scan_byte); end
    n_vec++; if (kv_cnt - kv0 !== 1) begin n_err++;
      $display("FAIL after_reset_pulses: got %0d expected 1", kv_cnt - kv0); end
  endtask

  initial begin
    wait_cyc(1);
    test_reset();
    test_make();
    test_extended();
    test_repeat();
    test_timeout();
    test_parity();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
